// File: rtl/ex_cnt_mod.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ex_cnt_mod : parametrised up/down counter with programmable modulus,     |
// |              sync clear/load, prescaler and wrap/saturate/one-shot ends. |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module ex_cnt_mod #(
  parameter int               WIDTH    = 10,
  parameter int               PRESCALE = 1,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dir_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] max_val_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o,
  output logic             sat_o,
  output logic             busy_o
);

  localparam logic [1:0] c_MODE_WRAP    = 2'b00;
  localparam logic [1:0] c_MODE_SAT     = 2'b01;
  localparam logic [1:0] c_MODE_ONESHOT = 2'b10;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             at_term;
  logic             halt;
  logic             step;

  // Up-count uses >= so a max_val lowered below cnt still terminates.
  always_comb begin
    at_term = dir_i ? (cnt_q >= max_val_i) : (cnt_q == '0);
    halt    = (mode_i == c_MODE_ONESHOT) && !busy_q;
  end

  generate
    if (PRESCALE > 1) begin : g_presc
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] c_PLAST = PW'(PRESCALE - 1);

      logic [PW-1:0] pcnt_q, pcnt_d;
      logic          pcnt_last;

      always_comb begin
        pcnt_last = (pcnt_q == c_PLAST);
        pcnt_d    = pcnt_q;
        if (clr_i || load_i) begin
          pcnt_d = '0;
        end else if (en_i && !halt) begin
          pcnt_d = pcnt_last ? '0 : pcnt_q + 1'b1;
        end
      end

      always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
          pcnt_q <= '0;
        end else begin
          pcnt_q <= pcnt_d;
        end
      end

      assign step = en_i && !halt && pcnt_last;
    end else begin : g_nopresc
      assign step = en_i && !halt;
    end
  endgenerate

  always_comb begin
    cnt_d  = cnt_q;
    tc_d   = 1'b0;
    busy_d = busy_q;
    if (clr_i) begin
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (load_i) begin
      cnt_d  = load_val_i;
      busy_d = 1'b1;
    end else if (step) begin
      tc_d = at_term;
      if (!at_term) begin
        cnt_d = dir_i ? cnt_q + 1'b1 : cnt_q - 1'b1;
      end else begin
        case (mode_i)
          c_MODE_SAT: cnt_d = cnt_q;
          c_MODE_ONESHOT: begin
            cnt_d  = dir_i ? '0 : max_val_i;
            busy_d = 1'b0;
          end
          default: cnt_d = dir_i ? '0 : max_val_i;
        endcase
      end
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= RST_VAL;
      tc_q   <= 1'b0;
      busy_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      tc_q   <= tc_d;
      busy_q <= busy_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign tc_o   = tc_q;
  assign busy_o = busy_q;
  assign sat_o  = (mode_i == c_MODE_SAT) && at_term;

endmodule
`default_nettype wire

// File: tb/tb_ex_cnt_mod.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ex_cnt_mod : directed self-checking bench for ex_cnt_mod.             |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_ex_cnt_mod;

  localparam int WIDTH = 10;

  logic             sclk = 1'b0;
  logic             rst_n;
  logic             en_i, clr_i, load_i, dir_i;
  logic [WIDTH-1:0] load_val_i, max_val_i;
  logic [1:0]       mode_i;
  logic [WIDTH-1:0] cnt_o, cnt4_o;
  logic             tc_o, sat_o, busy_o;
  logic             tc4_o, sat4_o, busy4_o;

  int n_total = 0;
  int n_bad   = 0;

  always #5 sclk = ~sclk;

  ex_cnt_mod #(.WIDTH(WIDTH), .PRESCALE(1), .RST_VAL(10'd0)) dut (
    .sclk(sclk), .rst_n(rst_n), .en_i(en_i), .clr_i(clr_i), .load_i(load_i),
    .load_val_i(load_val_i), .dir_i(dir_i), .mode_i(mode_i), .max_val_i(max_val_i),
    .cnt_o(cnt_o), .tc_o(tc_o), .sat_o(sat_o), .busy_o(busy_o)
  );

  ex_cnt_mod #(.WIDTH(WIDTH), .PRESCALE(4), .RST_VAL(10'd7)) dut4 (
    .sclk(sclk), .rst_n(rst_n), .en_i(en_i), .clr_i(clr_i), .load_i(load_i),
    .load_val_i(load_val_i), .dir_i(dir_i), .mode_i(mode_i), .max_val_i(max_val_i),
    .cnt_o(cnt4_o), .tc_o(tc4_o), .sat_o(sat4_o), .busy_o(busy4_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en_i = 1'b0; clr_i = 1'b0; load_i = 1'b0; dir_i = 1'b1;
    load_val_i = '0; max_val_i = 10'd5; mode_i = 2'b00;
    #12;
    check("rst_cnt",   32'(cnt_o), 0);
    check("rst_tc",    32'(tc_o), 0);
    check("rst_sat",   32'(sat_o), 0);
    check("rst_busy",  32'(busy_o), 1);
    check("rst_cnt4",  32'(cnt4_o), 7);
    #1 rst_n = 1'b1;

    // wrap up, max 5
    en_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("wrap_cnt", 32'(cnt_o), (i + 1) % 6);
      check("wrap_tc",  32'(tc_o), (i == 5) ? 1 : 0);
    end
    tick();
    check("wrap_cnt_after", 32'(cnt_o), 1);
    check("wrap_tc_after",  32'(tc_o), 0);

    // async reset mid-count at 37
    max_val_i = 10'd100; load_val_i = 10'd35; load_i = 1'b1;
    tick();
    check("load35", 32'(cnt_o), 35);
    load_i = 1'b0;
    tick(); tick();
    check("cnt37", 32'(cnt_o), 37);
    en_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cnt",  32'(cnt_o), 0);
    check("async_rst_tc",   32'(tc_o), 0);
    check("async_rst_cnt4", 32'(cnt4_o), 7);
    #1 rst_n = 1'b1;

    // down / saturate from 3
    dir_i = 1'b0; mode_i = 2'b01; load_val_i = 10'd3; load_i = 1'b1;
    tick();
    check("sat_load", 32'(cnt_o), 3);
    check("sat_sat0", 32'(sat_o), 0);
    load_i = 1'b0; en_i = 1'b1;
    tick(); check("sat_cnt2", 32'(cnt_o), 2);
    tick(); check("sat_cnt1", 32'(cnt_o), 1);
    check("sat_sat_at1", 32'(sat_o), 0);
    tick(); check("sat_cnt0", 32'(cnt_o), 0);
    check("sat_tc_reach", 32'(tc_o), 0);
    check("sat_sat_at0",  32'(sat_o), 1);
    tick(); check("sat_hold", 32'(cnt_o), 0);
    check("sat_tc1", 32'(tc_o), 1);
    tick(); check("sat_tc2", 32'(tc_o), 1);
    en_i = 1'b0;
    tick(); check("sat_tc_noen", 32'(tc_o), 0);
    check("sat_hold2", 32'(cnt_o), 0);

    // one-shot up, max 4
    dir_i = 1'b1; mode_i = 2'b10; max_val_i = 10'd4; clr_i = 1'b1;
    tick();
    clr_i = 1'b0; en_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("os_cnt", 32'(cnt_o), i);
      check("os_busy", 32'(busy_o), 1);
    end
    tick();
    check("os_end_cnt",  32'(cnt_o), 0);
    check("os_end_tc",   32'(tc_o), 1);
    check("os_end_busy", 32'(busy_o), 0);
    tick(); tick();
    check("os_idle_cnt",  32'(cnt_o), 0);
    check("os_idle_tc",   32'(tc_o), 0);
    check("os_idle_busy", 32'(busy_o), 0);
    load_i = 1'b1; load_val_i = 10'd2;
    tick();
    check("os_rearm_cnt",  32'(cnt_o), 2);
    check("os_rearm_busy", 32'(busy_o), 1);
    load_i = 1'b0;
    tick();
    check("os_rearm_step", 32'(cnt_o), 3);

    // down wrap reloads max_val; up with cnt above max wraps to 0
    mode_i = 2'b00; dir_i = 1'b0; max_val_i = 10'd9; clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    tick();
    check("dwrap_cnt", 32'(cnt_o), 9);
    check("dwrap_tc",  32'(tc_o), 1);
    dir_i = 1'b1; max_val_i = 10'd5; load_i = 1'b1; load_val_i = 10'd8;
    tick();
    load_i = 1'b0;
    tick();
    check("above_max_cnt", 32'(cnt_o), 0);
    check("above_max_tc",  32'(tc_o), 1);

    // priority
    clr_i = 1'b1; load_i = 1'b1; load_val_i = 10'd20;
    tick();
    check("prio_clr", 32'(cnt_o), 0);
    clr_i = 1'b0;
    tick();
    check("prio_load_cnt", 32'(cnt_o), 20);
    check("prio_load_tc",  32'(tc_o), 0);
    load_i = 1'b0;

    // prescale=4 on dut4
    en_i = 1'b0; max_val_i = 10'd100; clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    check("pre_clr", 32'(cnt4_o), 0);
    en_i = 1'b1; tick(); check("pre_e1", 32'(cnt4_o), 0);
    en_i = 1'b0; tick(); check("pre_e0", 32'(cnt4_o), 0);
    en_i = 1'b1; tick(); check("pre_e2", 32'(cnt4_o), 0);
    tick(); check("pre_e3", 32'(cnt4_o), 0);
    tick(); check("pre_e4", 32'(cnt4_o), 1);
    check("pre_tc", 32'(tc4_o), 0);
    tick(); tick(); tick();
    check("pre_mid", 32'(cnt4_o), 1);
    tick();
    check("pre_second", 32'(cnt4_o), 2);
    en_i = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
